// File: rtl/normalizer_pkg.sv
// rtl/normalizer_pkg.sv - shared types and helpers for the bit normalizer
//
// Contents:
//   norm_dir_e  : normalize direction (left = leading zeros, right = trailing zeros)
//   MAX_W       : widest word the bit-reverse helper handles
//   bitrev()    : reverse the low w bits of a MAX_W-bit vector
package normalizer_pkg;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } norm_dir_e;

  localparam int MAX_W = 64;

  // Reverse the whole MAX_W vector, then slide the reversed low-w field back
  // down to bit 0. Callers zero-extend to MAX_W and truncate the result to w.
  function automatic logic [MAX_W-1:0] bitrev(input logic [MAX_W-1:0] x, input int w);
    logic [MAX_W-1:0] r;
    r = {<<{x}};
    return r >> (MAX_W - w);
  endfunction

endpackage

// File: rtl/normalize_stage.sv
// rtl/normalize_stage.sv - one log-shifter stage of the normalizer pipeline
//
// Parameters: W word width, K shift size handled here, AW amount width.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   en                   global advance; all registers hold when low
//   in_valid/in_data/in_amt/in_dir/in_zero       stage inputs
//   out_valid/out_data/out_amt/out_dir/out_zero  registered stage outputs
module normalize_stage #(
  parameter int W  = 8,
  parameter int K  = 4,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          in_valid,
  input  logic [W-1:0]  in_data,
  input  logic [AW-1:0] in_amt,
  input  logic          in_dir,
  input  logic          in_zero,
  output logic          out_valid,
  output logic [W-1:0]  out_data,
  output logic [AW-1:0] out_amt,
  output logic          out_dir,
  output logic          out_zero
);

  // Amount bit owned by this stage: K = 2**AB.
  localparam int AB = $clog2(K);

  logic          lead_zero;
  logic [W-1:0]  next_data;
  logic [AW-1:0] next_amt;

  always_comb begin
    lead_zero     = ~|in_data[W-1 -: K];
    next_data     = lead_zero ? (in_data << K) : in_data;
    next_amt      = in_amt;
    next_amt[AB]  = lead_zero;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_amt   <= '0;
      out_dir   <= 1'b0;
      out_zero  <= 1'b0;
    end else if (en) begin
      out_valid <= in_valid;
      out_data  <= next_data;
      out_amt   <= next_amt;
      out_dir   <= in_dir;
      out_zero  <= in_zero;
    end
  end

endmodule

// File: rtl/pipelined_bit_normalizer.sv
// rtl/pipelined_bit_normalizer.sv - N-stage leading/trailing-zero normalizer
//
// Parameters: N log2 of word width (W = 2**N, N <= 6).
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid/in_ready/in_data   input word handshake
//   in_dir                      0 = left-normalize (clz), 1 = right-normalize (ctz)
//   out_valid/out_ready         result handshake
//   out_data                    normalized word
//   out_amt                     zero count / shift amount applied
//   out_zero                    input word was all zeros
module pipelined_bit_normalizer
  import normalizer_pkg::*;
#(
  parameter int  N = 3,
  localparam int W = 2 ** N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         in_dir,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [N-1:0] out_amt,
  output logic         out_zero
);

  // Chain index 0 is the combinational entry; index s+1 is the register of stage s.
  logic [W-1:0] c_data  [0:N];
  logic [N-1:0] c_amt   [0:N];
  logic         c_dir   [0:N];
  logic         c_zero  [0:N];
  logic         c_valid [0:N];

  logic advance;

  // Global stall: the last stage is the output register, so the whole pipe
  // moves only when that register is empty or being drained.
  assign advance  = !c_valid[N] || out_ready;
  assign in_ready = advance;

  // Right mode reuses the left-normalizing stages on a bit-reversed word.
  assign c_data[0]  = (norm_dir_e'(in_dir) == DIR_RIGHT)
                      ? W'(bitrev(MAX_W'(in_data), W)) : in_data;
  assign c_amt[0]   = '0;
  assign c_dir[0]   = in_dir;
  assign c_zero[0]  = ~|in_data;
  assign c_valid[0] = in_valid;

  for (genvar s = 0; s < N; s++) begin : g_stage
    normalize_stage #(
      .W  (W),
      .K  (1 << (N - 1 - s)),
      .AW (N)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (advance),
      .in_valid  (c_valid[s]),
      .in_data   (c_data[s]),
      .in_amt    (c_amt[s]),
      .in_dir    (c_dir[s]),
      .in_zero   (c_zero[s]),
      .out_valid (c_valid[s+1]),
      .out_data  (c_data[s+1]),
      .out_amt   (c_amt[s+1]),
      .out_dir   (c_dir[s+1]),
      .out_zero  (c_zero[s+1])
    );
  end

  // Exit reversal is a pure function of the last stage registers, so the
  // outputs stay stable while stalled.
  assign out_valid = c_valid[N];
  assign out_amt   = c_amt[N];
  assign out_zero  = c_zero[N];
  assign out_data  = (norm_dir_e'(c_dir[N]) == DIR_RIGHT)
                     ? W'(bitrev(MAX_W'(c_data[N]), W)) : c_data[N];

endmodule

// File: tb/tb_pipelined_bit_normalizer.sv
// tb/tb_pipelined_bit_normalizer.sv - self-checking bench for pipelined_bit_normalizer
module tb_pipelined_bit_normalizer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // N=3 instance
  logic        i3_valid, i3_ready, i3_dir, o3_valid, o3_ready, o3_zero;
  logic [7:0]  i3_data, o3_data;
  logic [2:0]  o3_amt;
  // N=5 instance
  logic        i5_valid, i5_ready, i5_dir, o5_valid, o5_ready, o5_zero;
  logic [31:0] i5_data, o5_data;
  logic [4:0]  o5_amt;

  pipelined_bit_normalizer #(.N(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(i3_valid), .in_ready(i3_ready), .in_data(i3_data), .in_dir(i3_dir),
    .out_valid(o3_valid), .out_ready(o3_ready), .out_data(o3_data),
    .out_amt(o3_amt), .out_zero(o3_zero)
  );

  pipelined_bit_normalizer #(.N(5)) dut5 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(i5_valid), .in_ready(i5_ready), .in_data(i5_data), .in_dir(i5_dir),
    .out_valid(o5_valid), .out_ready(o5_ready), .out_data(o5_data),
    .out_amt(o5_amt), .out_zero(o5_zero)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: {zero, amt[7:0], data[31:0]} from plain clz/ctz arithmetic.
  function automatic logic [63:0] model(input logic [31:0] d, input logic dir, input int n);
    int w;
    int amt;
    int msb;
    int lsb;
    logic [63:0] o;
    w = 1 << n;
    if (d == 0) return {23'b0, 1'b1, 8'(w - 1), 32'b0};
    msb = 0;
    lsb = 0;
    for (int i = 0; i < w; i++) if (d[i]) msb = i;
    for (int i = w - 1; i >= 0; i--) if (d[i]) lsb = i;
    if (!dir) begin
      amt = w - 1 - msb;
      o   = (64'(d) << amt) & ((64'(1) << w) - 1);
    end else begin
      amt = lsb;
      o   = 64'(d) >> amt;
    end
    return {23'b0, 1'b0, 8'(amt), o[31:0]};
  endfunction

  function automatic logic [31:0] rnd_word(input int w);
    logic [31:0] r;
    case ($urandom_range(0, 5))
      0: r = 32'h0;
      1: r = 32'(1) << $urandom_range(0, w - 1);
      2: r = $urandom >> $urandom_range(0, 31);
      default: r = $urandom;
    endcase
    if (w < 32) r = r & ((32'(1) << w) - 1);
    return r;
  endfunction

  // Scoreboards and monitors: sampled on the falling edge, where the
  // handshake values decide the transfer at the following rising edge.
  logic [63:0] q3[$];
  logic [63:0] q5[$];
  logic [63:0] e3, e5;
  logic        hold3 = 1'b0, hold5 = 1'b0;
  logic [31:0] held3, held5;
  int          out3_cnt = 0, out5_cnt = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      q3.delete();
      hold3 = 1'b0;
    end else begin
      chk("in_ready3", 32'(i3_ready), 32'(!o3_valid || o3_ready));
      if (hold3) begin
        chk("frozen_valid3", 32'(o3_valid), 32'd1);
        chk("frozen_out3", {20'b0, o3_zero, o3_amt, o3_data}, held3);
      end
      hold3 = o3_valid && !o3_ready;
      held3 = {20'b0, o3_zero, o3_amt, o3_data};
      if (i3_valid && i3_ready) q3.push_back(model(32'(i3_data), i3_dir, 3));
      if (o3_valid && o3_ready) begin
        out3_cnt++;
        if (q3.size() == 0) chk("unexpected_out3", 32'd1, 32'd0);
        else begin
          e3 = q3.pop_front();
          chk("data3", 32'(o3_data), 32'(e3[7:0]));
          chk("amt3", 32'(o3_amt), 32'(e3[34:32]));
          chk("zero3", 32'(o3_zero), 32'(e3[40]));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      q5.delete();
      hold5 = 1'b0;
    end else begin
      chk("in_ready5", 32'(i5_ready), 32'(!o5_valid || o5_ready));
      if (hold5) begin
        chk("frozen_valid5", 32'(o5_valid), 32'd1);
        chk("frozen_data5", o5_data, held5);
      end
      hold5 = o5_valid && !o5_ready;
      held5 = o5_data;
      if (i5_valid && i5_ready) q5.push_back(model(i5_data, i5_dir, 5));
      if (o5_valid && o5_ready) begin
        out5_cnt++;
        if (q5.size() == 0) chk("unexpected_out5", 32'd1, 32'd0);
        else begin
          e5 = q5.pop_front();
          chk("data5", o5_data, e5[31:0]);
          chk("amt5", 32'(o5_amt), 32'(e5[36:32]));
          chk("zero5", 32'(o5_zero), 32'(e5[40]));
        end
      end
    end
  end

  task automatic send3(input logic [7:0] d, input logic dir);
    int t;
    i3_valid = 1'b1;
    i3_data  = d;
    i3_dir   = dir;
    t = 0;
    @(negedge clk);
    while (!i3_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("timeout_in3", 32'd0, 32'd1);
    @(posedge clk);
    #1 i3_valid = 1'b0;
  endtask

  task automatic send5(input logic [31:0] d, input logic dir);
    int t;
    i5_valid = 1'b1;
    i5_data  = d;
    i5_dir   = dir;
    t = 0;
    @(negedge clk);
    while (!i5_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("timeout_in5", 32'd0, 32'd1);
    @(posedge clk);
    #1 i5_valid = 1'b0;
  endtask

  // One word through an idle pipe: latency and literal result.
  task automatic run_one(input logic [7:0] d, input logic dir,
                         input logic [7:0] xd, input logic [2:0] xa, input logic xz);
    int cyc;
    o3_ready = 1'b1;
    send3(d, dir);
    cyc = 1;
    while (!o3_valid && cyc < 20) begin
      @(posedge clk);
      #1 cyc++;
    end
    chk("latency", 32'(cyc), 32'd3);
    chk("lit_data", 32'(o3_data), 32'(xd));
    chk("lit_amt", 32'(o3_amt), 32'(xa));
    chk("lit_zero", 32'(o3_zero), 32'(xz));
    repeat (2) @(posedge clk);
    #1;
  endtask

  logic [31:0] w;
  int          n;
  logic        done3, done5;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    i3_valid = 1'b0; i3_data = '0; i3_dir = 1'b0; o3_ready = 1'b0;
    i5_valid = 1'b0; i5_data = '0; i5_dir = 1'b0; o5_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid3", 32'(o3_valid), 32'd0);
    chk("rst_out_data3", 32'(o3_data), 32'd0);
    chk("rst_out_amt3", 32'(o3_amt), 32'd0);
    chk("rst_out_zero3", 32'(o3_zero), 32'd0);
    chk("rst_in_ready3", 32'(i3_ready), 32'd1);
    chk("rst_out_valid5", 32'(o5_valid), 32'd0);
    chk("rst_in_ready5", 32'(i5_ready), 32'd1);
    @(posedge clk);
    #1;

    run_one(8'b0001_0110, 1'b0, 8'b1011_0000, 3'd3, 1'b0);
    run_one(8'b0001_0110, 1'b1, 8'b0000_1011, 3'd1, 1'b0);
    run_one(8'h00, 1'b0, 8'h00, 3'd7, 1'b1);
    run_one(8'h00, 1'b1, 8'h00, 3'd7, 1'b1);
    run_one(8'h80, 1'b0, 8'h80, 3'd0, 1'b0);
    run_one(8'h80, 1'b1, 8'h01, 3'd7, 1'b0);

    // 8-word stream at full rate: results must leave on 8 consecutive cycles.
    o3_ready = 1'b1;
    fork
      for (int k = 0; k < 8; k++) begin
        w = rnd_word(8);
        send3(w[7:0], k[0]);
      end
      begin
        int t;
        t = 0;
        @(negedge clk);
        while (!o3_valid && t < 50) begin
          @(negedge clk);
          t++;
        end
        n = 0;
        repeat (8) begin
          if (o3_valid) n++;
          @(negedge clk);
        end
        chk("stream_rate", 32'(n), 32'd8);
      end
    join
    repeat (6) @(posedge clk);
    #1;

    // 8-word stream with a 4-cycle downstream stall in the middle.
    n = out3_cnt;
    fork
      for (int k = 0; k < 8; k++) begin
        w = rnd_word(8);
        send3(w[7:0], k[1]);
      end
      begin
        repeat (5) @(posedge clk);
        #1 o3_ready = 1'b0;
        @(negedge clk);
        chk("stall_in_ready", 32'(i3_ready), 32'd0);
        repeat (4) @(posedge clk);
        #1 o3_ready = 1'b1;
      end
    join
    repeat (8) @(posedge clk);
    #1;
    chk("stall_count", 32'(out3_cnt - n), 32'd8);
    chk("stall_queue_empty", 32'(q3.size()), 32'd0);

    // Reset with three words in flight.
    send3(8'h21, 1'b0);
    send3(8'h40, 1'b1);
    send3(8'h07, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(o3_valid), 32'd0);
    chk("arst_out_data", 32'(o3_data), 32'd0);
    chk("arst_out_amt", 32'(o3_amt), 32'd0);
    chk("arst_out_zero", 32'(o3_zero), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (o3_valid) n++;
    end
    chk("stale_after_reset", 32'(n), 32'd0);
    @(posedge clk);
    #1;
    run_one(8'h01, 1'b0, 8'h80, 3'd7, 1'b0);

    // Random traffic on both widths with random backpressure.
    done3 = 1'b0;
    done5 = 1'b0;
    fork
      begin
        for (int k = 0; k < 300; k++) begin
          if ($urandom_range(0, 3) != 0) begin
            w = rnd_word(8);
            send3(w[7:0], 1'($urandom_range(0, 1)));
          end else begin
            @(posedge clk);
            #1;
          end
        end
        done3 = 1'b1;
      end
      begin
        while (!done3) begin
          @(posedge clk);
          #1 o3_ready = ($urandom_range(0, 3) != 0);
        end
        o3_ready = 1'b1;
      end
      begin
        for (int k = 0; k < 300; k++) begin
          if ($urandom_range(0, 3) != 0) send5(rnd_word(32), 1'($urandom_range(0, 1)));
          else begin
            @(posedge clk);
            #1;
          end
        end
        done5 = 1'b1;
      end
      begin
        while (!done5) begin
          @(posedge clk);
          #1 o5_ready = ($urandom_range(0, 3) != 0);
        end
        o5_ready = 1'b1;
      end
    join
    repeat (20) @(posedge clk);
    #1;
    chk("drain_q3", 32'(q3.size()), 32'd0);
    chk("drain_q5", 32'(q5.size()), 32'd0);
    chk("rand_outputs5_seen", 32'(out5_cnt > 150), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
